logic_unit_pipe: RTL and testbench

- Parametrised, pipelined bitwise logic unit; successor to the 16-bit combinational NOT gate.
- Performs one of eight bitwise operations on WIDTH-bit operands and produces status flags.
- Two register stages with a valid/ready handshake on input and output.
- Sits between the ALU operand mux and the ALU result mux, alongside the arithmetic unit.

---
 rtl/logic_unit_pipe.sv | 168 ++++++++++++++++
 tb/tb_logic_unit_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshake and status flags.
// Optional popcount output enabled by defining LOGIC_UNIT_POPCNT_EN.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity,
    output logic [CNT_W-1:0] op_count
`ifdef LOGIC_UNIT_POPCNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] out_popcnt
`endif
);

    localparam logic [2:0] OpNot  = 3'b000;
    localparam logic [2:0] OpAnd  = 3'b001;
    localparam logic [2:0] OpOr   = 3'b010;
    localparam logic [2:0] OpXor  = 3'b011;
    localparam logic [2:0] OpNand = 3'b100;
    localparam logic [2:0] OpNor  = 3'b101;
    localparam logic [2:0] OpXnor = 3'b110;
    localparam logic [2:0] OpPass = 3'b111;

    logic             s1_load, s2_load;
    logic             v1_q, v1_d, v2_q, v2_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] r_q, r_d;
    logic             zero_q, zero_d, ones_q, ones_d, par_q, par_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef LOGIC_UNIT_POPCNT_EN
    localparam int unsigned PcW = $clog2(WIDTH + 1);
    logic [PcW-1:0] pc_q, pc_d, pc_res;

    always_comb begin
        pc_res = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            pc_res = pc_res + PcW'(res[i]);
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (s2_load && v1_q) begin
            pc_d = pc_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign out_popcnt = pc_q;
`endif

    // No skid buffer: in_ready is combinational from out_ready.
    assign s2_load  = !v2_q || out_ready;
    assign s1_load  = !v1_q || s2_load;
    assign in_ready = s1_load;

    always_comb begin
        v1_d = v1_q;
        op_d = op_q;
        a_d  = a_q;
        b_d  = b_q;
        if (s1_load) begin
            v1_d = in_valid;
            if (in_valid) begin
                op_d = in_op;
                a_d  = in_a;
                b_d  = in_b;
            end
        end
    end

    // NOT and PASS select only a_q, so an unknown b never reaches the result.
    always_comb begin
        res = '0;
        unique case (op_q)
            OpNot:  res = ~a_q;
            OpAnd:  res = a_q & b_q;
            OpOr:   res = a_q | b_q;
            OpXor:  res = a_q ^ b_q;
            OpNand: res = ~(a_q & b_q);
            OpNor:  res = ~(a_q | b_q);
            OpXnor: res = ~(a_q ^ b_q);
            OpPass: res = a_q;
            default: res = '0;
        endcase
    end

    // A bubble advancing into S2 clears v2 but leaves the visible result untouched.
    always_comb begin
        v2_d   = v2_q;
        r_d    = r_q;
        zero_d = zero_q;
        ones_d = ones_q;
        par_d  = par_q;
        if (s2_load) begin
            v2_d = v1_q;
            if (v1_q) begin
                r_d    = res;
                zero_d = (res == '0);
                ones_d = &res;
                par_d  = ^res;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (v2_q && out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            v2_q   <= 1'b0;
            r_q    <= '0;
            zero_q <= 1'b1;
            ones_q <= 1'b0;
            par_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            v1_q   <= v1_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            v2_q   <= v2_d;
            r_q    <= r_d;
            zero_q <= zero_d;
            ones_q <= ones_d;
            par_q  <= par_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid  = v2_q;
    assign out_r      = r_q;
    assign out_zero   = zero_q;
    assign out_ones   = ones_q;
    assign out_parity = par_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: truth-table reference model, directed and random traffic.
module tb_logic_unit_pipe;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, out_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a, in_b;
    logic         in_ready, out_valid, out_zero, out_ones, out_parity;
    logic [W-1:0] out_r;
    logic [15:0]  op_count;
    logic         in_ready2, out_valid2, out_zero2, out_ones2, out_parity2;
    logic [W-1:0] out_r2;
    logic [1:0]   op_count2;
`ifdef LOGIC_UNIT_POPCNT_EN
    logic [4:0]   out_popcnt, out_popcnt2;
`endif

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic         held_v = 1'b0;
    logic [W-1:0] held_r;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(W), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
        .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity), .op_count(op_count)
`ifdef LOGIC_UNIT_POPCNT_EN
        , .out_popcnt(out_popcnt)
`endif
    );

    logic_unit_pipe #(.WIDTH(W), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid2), .out_ready(out_ready), .out_r(out_r2),
        .out_zero(out_zero2), .out_ones(out_ones2), .out_parity(out_parity2),
        .op_count(op_count2)
`ifdef LOGIC_UNIT_POPCNT_EN
        , .out_popcnt(out_popcnt2)
`endif
    );

    // Each op is a truth table indexed by {a_bit, b_bit}.
    function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [3:0] tt;
        logic [W-1:0] r;
        case (op)
            3'd0: tt = 4'b0011;
            3'd1: tt = 4'b1000;
            3'd2: tt = 4'b1110;
            3'd3: tt = 4'b0110;
            3'd4: tt = 4'b0111;
            3'd5: tt = 4'b0001;
            3'd6: tt = 4'b1001;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < W; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    function automatic int ones_in(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) if (v[i]) n++;
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        @(negedge clk);
    endtask

    // Stimulus side of the scoreboard: every accepted input pushes its expected result.
    always @(negedge clk) begin
        if (rst) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back(ref_result(in_op, in_a, in_b));
    end

    // Monitor: counter, stall stability and in-order results.
    always @(negedge clk) begin
        if (rst) begin
            exp_cnt = 0;
            held_v  = 1'b0;
        end else begin
            logic [W-1:0] e;
            int n;
            check("op_count", 64'(op_count), 64'(exp_cnt));
            check("op_count_sat", 64'(op_count2), 64'((exp_cnt > 3) ? 3 : exp_cnt));
            if (held_v) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_hold", 64'(out_r), 64'(held_r));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=none", out_r);
                end else begin
                    e = exp_q.pop_front();
                    n = ones_in(e);
                    check("result", 64'(out_r), 64'(e));
                    check("zero", 64'(out_zero), 64'(n == 0));
                    check("ones", 64'(out_ones), 64'(n == W));
                    check("parity", 64'(out_parity), 64'(n % 2));
`ifdef LOGIC_UNIT_POPCNT_EN
                    check("popcnt", 64'(out_popcnt), 64'(n));
`endif
                end
                exp_cnt++;
            end
            held_v = out_valid && !out_ready;
            held_r = out_r;
        end
    end

    initial begin
        logic [W-1:0] t2_res[4];
        logic [2:0]   t2_op[4];
        rst = 1'b1;
        in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_r", 64'(out_r), 64'd0);
        check("rst_zero", 64'(out_zero), 64'd1);
        check("rst_ones", 64'(out_ones), 64'd0);
        check("rst_parity", 64'(out_parity), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // NOT 248 with two-cycle latency
        step(1'b1, 3'b000, 16'd248, 16'h0, 1'b1);
        check("t1_in_ready", 64'(in_ready), 64'd1);
        step(1'b0, 3'b000, 16'h0, 16'h0, 1'b1);
        check("t1_not_early", 64'(out_valid), 64'd0);
        step(1'b0, 3'b000, 16'h0, 16'h0, 1'b1);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_r", 64'(out_r), 64'hFF07);
        check("t1_parity", 64'(out_parity), 64'd1);
        step(1'b0, 3'b000, 16'h0, 16'h0, 1'b1);
        check("t1_count", 64'(op_count), 64'd1);

        // Back-to-back AND/OR/XOR/NOR
        t2_op[0] = 3'b001; t2_res[0] = 16'hF000;
        t2_op[1] = 3'b010; t2_res[1] = 16'hFFF0;
        t2_op[2] = 3'b011; t2_res[2] = 16'h0FF0;
        t2_op[3] = 3'b101; t2_res[3] = 16'h000F;
        for (int i = 0; i < 6; i++) begin
            step(i < 4, (i < 4) ? t2_op[i] : 3'b000, 16'hF0F0, 16'hFF00, 1'b1);
            if (i < 4) check("t2_in_ready", 64'(in_ready), 64'd1);
            if (i >= 2) begin
                check("t2_valid", 64'(out_valid), 64'd1);
                check("t2_r", 64'(out_r), 64'(t2_res[i-2]));
            end
        end

        // XNOR, NAND, PASS
        step(1'b1, 3'b110, 16'h1234, 16'h1234, 1'b1);
        step(1'b1, 3'b100, 16'hFFFF, 16'hFFFF, 1'b1);
        step(1'b1, 3'b111, 16'h00FF, 16'hDEAD, 1'b1);
        check("t3_xnor_r", 64'(out_r), 64'hFFFF);
        check("t3_xnor_ones", 64'(out_ones), 64'd1);
        check("t3_xnor_par", 64'(out_parity), 64'd0);
        step(1'b0, 3'b000, 16'h0, 16'h0, 1'b1);
        check("t3_nand_r", 64'(out_r), 64'h0);
        check("t3_nand_zero", 64'(out_zero), 64'd1);
        step(1'b0, 3'b000, 16'h0, 16'h0, 1'b1);
        check("t3_pass_r", 64'(out_r), 64'h00FF);
`ifdef LOGIC_UNIT_POPCNT_EN
        check("t3_popcnt", 64'(out_popcnt), 64'd8);
`endif

        // Stall with three offers
        step(1'b1, 3'b001, 16'hA5A5, 16'h0FF0, 1'b0);
        check("t4_acc0", 64'(in_ready), 64'd1);
        step(1'b1, 3'b010, 16'h1111, 16'h2222, 1'b0);
        check("t4_acc1", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'b011, 16'h3C3C, 16'hFFFF, 1'b0);
            check("t4_full", 64'(in_ready), 64'd0);
        end
        step(1'b1, 3'b011, 16'h3C3C, 16'hFFFF, 1'b1);
        check("t4_resume", 64'(in_ready), 64'd1);
        repeat (4) step(1'b0, 3'b000, 16'h0, 16'h0, 1'b1);
        check("t4_drained", 64'(exp_q.size()), 64'd0);

        // Reset with both stages full
        step(1'b1, 3'b000, 16'h1234, 16'h0, 1'b0);
        step(1'b1, 3'b000, 16'h5678, 16'h0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_count", 64'(op_count), 64'd0);
        check("t5_zero", 64'(out_zero), 64'd1);
        check("t5_in_ready", 64'(in_ready), 64'd1);
        repeat (4) step(1'b0, 3'b000, 16'h0, 16'h0, 1'b1);
        check("t5_no_stale", 64'(out_valid), 64'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, 3'($urandom), W'($urandom), W'($urandom),
                 $urandom_range(0, 9) < 7);
        end
        repeat (5) step(1'b0, 3'b000, 16'h0, 16'h0, 1'b1);
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
